hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller that generates the stall and flush controls consumed by the PC, IF/ID and ID/EX pipeline registers.
- Detects load-use hazards between the instruction in ID/EX and the one in IF/ID, and inserts bubbles for them.
- Sequences the flush of wrong-path instructions after a taken branch, jump or jump-register resolves in EX.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- REG_ADDR, 5: register specifier width.
- LOAD_STALL_CYCLES, 1: bubbles inserted per load-use hazard; legal range 1..4.
- FLUSH_CYCLES, 1: cycles IF/ID and ID/EX are flushed per redirect; legal range 1..4.
- CNT_WIDTH, 16: width of the performance counters.

Ports:
- clk  input  1  clock; all state updates on the falling edge, matching the pipeline registers.
- reset  input  1  synchronous, active-high.
- ifid_rs  input  REG_ADDR  rs field of the instruction in IF/ID.
- ifid_rt  input  REG_ADDR  rt field of the instruction in IF/ID.
- ifid_uses_rs  input  1  the IF/ID instruction reads rs.
- ifid_uses_rt  input  1  the IF/ID instruction reads rt.
- idex_rt  input  REG_ADDR  load destination of the instruction in ID/EX.
- idex_memtoreg  input  1  the ID/EX instruction is a load.
- idex_regwrite  input  1  the ID/EX instruction writes a register.
- branch_taken_ex  input  1  branch resolved taken in EX.
- jump_ex  input  1  jump in EX.
- jregister_ex  input  1  jump-register in EX.
- clr_cnt  input  1  synchronous clear of both counters.
- pc_stall  output  1  hold the PC.
- ifid_stall  output  1  hold IF/ID.
- ifid_flush  output  1  zero IF/ID.
- idex_flush  output  1  zero ID/EX; drives the ID/EX register's flush input.
- busy  output  1  FSM is not in RUN.
- stall_cnt  output  CNT_WIDTH  cycles with pc_stall asserted.
- flush_cnt  output  CNT_WIDTH  cycles with ifid_flush asserted.

Behaviour:
- Signal definitions:
  - redirect = branch_taken_ex | jump_ex | jregister_ex.
  - load_use = idex_memtoreg & idex_regwrite & (idex_rt != 0) & ((ifid_uses_rs & idex_rt == ifid_rs) | (ifid_uses_rt & idex_rt == ifid_rt)).
- FSM states: RUN, LSTALL, REDIR. A down-counter cnt (2 bits) sits alongside the FSM.
- Outputs are combinational from state and the current inputs (Mealy), so a hazard is acted on in the same cycle it is detected.
- Priority, in every state: reset > redirect > load_use.
- RUN:
  - redirect: ifid_flush=1, idex_flush=1. Next state is REDIR with cnt=FLUSH_CYCLES-2 if FLUSH_CYCLES>1; otherwise stay in RUN.
  - Else load_use: pc_stall=1, ifid_stall=1, idex_flush=1. Next state is LSTALL with cnt=LOAD_STALL_CYCLES-2 if LOAD_STALL_CYCLES>1; otherwise stay in RUN.
  - Else all control outputs are 0.
- LSTALL:
  - pc_stall=1, ifid_stall=1, idex_flush=1.
  - If cnt==0, go to RUN; else decrement cnt.
  - A redirect arriving in LSTALL overrides: flush outputs replace the stall outputs (pc_stall=0, ifid_stall=0), load cnt=FLUSH_CYCLES-2 and go to REDIR, or to RUN if FLUSH_CYCLES==1.
- REDIR:
  - ifid_flush=1, idex_flush=1; pc_stall=0; load_use is ignored.
  - If cnt==0, go to RUN; else decrement cnt.
  - A new redirect reloads cnt and stays in REDIR.
- Stall and flush are mutually exclusive: ifid_stall and ifid_flush are never both 1.
- busy = (state != RUN).
- Counters:
  - Saturate at all-ones, with no wrap.
  - Increment on each falling edge where the respective output is 1.
  - clr_cnt has priority over an increment; a clear and an increment in the same cycle yields 0.
- Reset:
  - state=RUN, cnt=0, stall_cnt=0, flush_cnt=0.
  - While reset=1, all control outputs are forced to 0.
  - A reset asserted in the middle of LSTALL or REDIR aborts the sequence; the FSM is in RUN on the next edge.

Decomposition:
- Package mips_pipe_pkg holds:
  - hazard_state_t enum {RUN, LSTALL, REDIR}.
  - REG_ZERO constant = 5'd0.
- Sub-module sat_counter (parameter WIDTH; inputs clk, reset, clr, inc; output count) is instantiated twice, once for stall_cnt and once for flush_cnt.

Test Plan:
- Load-use on rs, default parameters: idex_memtoreg=1, idex_regwrite=1, idex_rt=5'd8, ifid_rs=5'd8, ifid_uses_rs=1 -> pc_stall=ifid_stall=idex_flush=1 for exactly one cycle; then all 0; stall_cnt=1.
- Load to $zero: idex_rt=0=ifid_rs with the load bits set -> no stall; all outputs stay 0.
- FLUSH_CYCLES=3, jump_ex pulsed for one cycle -> ifid_flush=idex_flush=1 for 3 consecutive cycles; busy=1 in cycles 2-3; flush_cnt=3.
- Simultaneous load_use and branch_taken_ex in RUN -> flush only (pc_stall=0, ifid_flush=1); stall_cnt unchanged.
- LOAD_STALL_CYCLES=3; assert reset in the second LSTALL cycle -> outputs 0 during reset; state RUN after the edge; both counters 0.
- Saturation with CNT_WIDTH=4: 20 back-to-back load-use hazards -> stall_cnt holds at 15; then clr_cnt=1 -> 0.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline control blocks.
//
// Contents:
//   hazard_state_t : hazard controller FSM states (RUN, LSTALL, REDIR)
//   REG_ZERO       : architectural $zero register specifier
package mips_pipe_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    REDIR  = 2'd2
  } hazard_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard controller performance counters.
// Updates on the falling clock edge, like the pipeline registers it observes.
//
// Ports:
//   clk   : clock (falling edge active)
//   reset : synchronous, active-high; clears the count
//   clr   : synchronous clear; wins over inc
//   inc   : count one event this cycle
//   count : current count, holds at all-ones instead of wrapping
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: generates stall/flush controls for the PC,
// IF/ID and ID/EX registers. Inserts bubbles on load-use hazards and flushes
// wrong-path instructions after a redirect (taken branch, jump, jump-register)
// resolves in EX. Also keeps saturating stall and flush event counters.
// All state changes on the falling clock edge.
//
// Ports:
//   clk, reset            : clock (negedge), synchronous active-high reset
//   ifid_rs/rt, uses_rs/rt: source registers of the IF/ID instruction
//   idex_rt, memtoreg,
//   idex_regwrite         : destination / load info of the ID/EX instruction
//   branch_taken_ex,
//   jump_ex, jregister_ex : redirect sources resolved in EX
//   clr_cnt               : synchronous clear of both counters
//   pc_stall, ifid_stall  : hold PC / IF/ID
//   ifid_flush, idex_flush: zero IF/ID / ID/EX
//   busy                  : FSM is in a multi-cycle stall or flush sequence
//   stall_cnt, flush_cnt  : cycles with pc_stall / ifid_flush asserted
module hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int REG_ADDR          = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int CNT_WIDTH         = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_ADDR-1:0]  ifid_rs,
  input  logic [REG_ADDR-1:0]  ifid_rt,
  input  logic                 ifid_uses_rs,
  input  logic                 ifid_uses_rt,
  input  logic [REG_ADDR-1:0]  idex_rt,
  input  logic                 idex_memtoreg,
  input  logic                 idex_regwrite,
  input  logic                 branch_taken_ex,
  input  logic                 jump_ex,
  input  logic                 jregister_ex,
  input  logic                 clr_cnt,
  output logic                 pc_stall,
  output logic                 ifid_stall,
  output logic                 ifid_flush,
  output logic                 idex_flush,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  // The cycle that detects the event is the first stall/flush cycle, so the
  // down-counter only covers the remaining cycles (N-2 down to 0).
  localparam bit         FLUSH_MULTI = (FLUSH_CYCLES > 1);
  localparam bit         LOAD_MULTI  = (LOAD_STALL_CYCLES > 1);
  localparam logic [1:0] FLUSH_LOAD  = 2'(FLUSH_MULTI ? FLUSH_CYCLES - 2 : 0);
  localparam logic [1:0] LOAD_LOAD   = 2'(LOAD_MULTI ? LOAD_STALL_CYCLES - 2 : 0);

  hazard_state_t state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;

  logic redirect;
  logic load_use;
  logic rs_hit;
  logic rt_hit;

  assign redirect = branch_taken_ex | jump_ex | jregister_ex;
  assign rs_hit   = ifid_uses_rs & (idex_rt == ifid_rs);
  assign rt_hit   = ifid_uses_rt & (idex_rt == ifid_rt);
  // Loads into $zero never produce a value, so they cannot cause a hazard.
  assign load_use = idex_memtoreg & idex_regwrite &
                    (idex_rt != REG_ADDR'(REG_ZERO)) & (rs_hit | rt_hit);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;

    if (reset) begin
      state_d = RUN;
      cnt_d   = 2'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            if (FLUSH_MULTI) begin
              state_d = REDIR;
              cnt_d   = FLUSH_LOAD;
            end
          end else if (load_use) begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            if (LOAD_MULTI) begin
              state_d = LSTALL;
              cnt_d   = LOAD_LOAD;
            end
          end
        end

        LSTALL: begin
          // A redirect squashes the stalled instruction anyway, so the
          // remaining bubbles are abandoned in favour of the flush.
          if (redirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            cnt_d      = FLUSH_LOAD;
            state_d    = FLUSH_MULTI ? REDIR : RUN;
          end else begin
            pc_stall   = 1'b1;
            ifid_stall = 1'b1;
            idex_flush = 1'b1;
            if (cnt_q == 2'd0) begin
              state_d = RUN;
            end else begin
              cnt_d = cnt_q - 2'd1;
            end
          end
        end

        REDIR: begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (redirect) begin
            cnt_d = FLUSH_LOAD;
          end else if (cnt_q == 2'd0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end

        default: begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != RUN);

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cnt),
    .inc   (pc_stall),
    .count (stall_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_WIDTH)
  ) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_cnt),
    .inc   (ifid_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. Two instances share the inputs:
//   dut_a : default parameters (1-cycle stall, 1-cycle flush, 16-bit counters)
//   dut_b : LOAD_STALL_CYCLES=3, FLUSH_CYCLES=3, CNT_WIDTH=4
// Inputs change just after the rising edge; outputs are checked before the
// falling edge, where the DUT updates its state.
// Control vectors are packed {pc_stall, ifid_stall, ifid_flush, idex_flush, busy}.
module tb_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       ifid_uses_rs;
  logic       ifid_uses_rt;
  logic [4:0] idex_rt;
  logic       idex_memtoreg;
  logic       idex_regwrite;
  logic       branch_taken_ex;
  logic       jump_ex;
  logic       jregister_ex;
  logic       clr_cnt;

  logic        a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_flush, a_busy;
  logic [15:0] a_stall_cnt, a_flush_cnt;
  logic        b_pc_stall, b_ifid_stall, b_ifid_flush, b_idex_flush, b_busy;
  logic [3:0]  b_stall_cnt, b_flush_cnt;

  logic [4:0] a_ctl;
  logic [4:0] b_ctl;
  assign a_ctl = {a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_flush, a_busy};
  assign b_ctl = {b_pc_stall, b_ifid_stall, b_ifid_flush, b_idex_flush, b_busy};

  int vectors;
  int miscompares;

  hazard_ctrl dut_a (
    .clk             (clk),
    .reset           (reset),
    .ifid_rs         (ifid_rs),
    .ifid_rt         (ifid_rt),
    .ifid_uses_rs    (ifid_uses_rs),
    .ifid_uses_rt    (ifid_uses_rt),
    .idex_rt         (idex_rt),
    .idex_memtoreg   (idex_memtoreg),
    .idex_regwrite   (idex_regwrite),
    .branch_taken_ex (branch_taken_ex),
    .jump_ex         (jump_ex),
    .jregister_ex    (jregister_ex),
    .clr_cnt         (clr_cnt),
    .pc_stall        (a_pc_stall),
    .ifid_stall      (a_ifid_stall),
    .ifid_flush      (a_ifid_flush),
    .idex_flush      (a_idex_flush),
    .busy            (a_busy),
    .stall_cnt       (a_stall_cnt),
    .flush_cnt       (a_flush_cnt)
  );

  hazard_ctrl #(
    .REG_ADDR          (5),
    .LOAD_STALL_CYCLES (3),
    .FLUSH_CYCLES      (3),
    .CNT_WIDTH         (4)
  ) dut_b (
    .clk             (clk),
    .reset           (reset),
    .ifid_rs         (ifid_rs),
    .ifid_rt         (ifid_rt),
    .ifid_uses_rs    (ifid_uses_rs),
    .ifid_uses_rt    (ifid_uses_rt),
    .idex_rt         (idex_rt),
    .idex_memtoreg   (idex_memtoreg),
    .idex_regwrite   (idex_regwrite),
    .branch_taken_ex (branch_taken_ex),
    .jump_ex         (jump_ex),
    .jregister_ex    (jregister_ex),
    .clr_cnt         (clr_cnt),
    .pc_stall        (b_pc_stall),
    .ifid_stall      (b_ifid_stall),
    .ifid_flush      (b_ifid_flush),
    .idex_flush      (b_idex_flush),
    .busy            (b_busy),
    .stall_cnt       (b_stall_cnt),
    .flush_cnt       (b_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge (mid-cycle between DUT updates).
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    ifid_rs         = 5'd0;
    ifid_rt         = 5'd0;
    ifid_uses_rs    = 1'b0;
    ifid_uses_rt    = 1'b0;
    idex_rt         = 5'd0;
    idex_memtoreg   = 1'b0;
    idex_regwrite   = 1'b0;
    branch_taken_ex = 1'b0;
    jump_ex         = 1'b0;
    jregister_ex    = 1'b0;
  endtask

  task automatic set_load_use_rs();
    idex_memtoreg = 1'b1;
    idex_regwrite = 1'b1;
    idex_rt       = 5'd8;
    ifid_rs       = 5'd8;
    ifid_uses_rs  = 1'b1;
  endtask

  // Let both instances drain to RUN, then clear the counters.
  task automatic idle();
    for (int i = 0; i < 4; i++) begin
      cyc();
      zero_inputs();
      clr_cnt = 1'b0;
    end
    cyc();
    clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
  endtask

  task automatic test_reset();
    zero_inputs();
    clr_cnt = 1'b0;
    reset   = 1'b1;
    cyc();
    cyc();
    #1;
    vectors++;
    if ((a_ctl !== 5'b00000) || (b_ctl !== 5'b00000)) begin
      miscompares++;
      $display("[TB] FAIL reset_ctl: got a=%b b=%b want 00000", a_ctl, b_ctl);
    end
    vectors++;
    if ((a_stall_cnt !== 16'd0) || (a_flush_cnt !== 16'd0) ||
        (b_stall_cnt !== 4'd0) || (b_flush_cnt !== 4'd0)) begin
      miscompares++;
      $display("[TB] FAIL reset_cnt: got a=%0d/%0d b=%0d/%0d want 0", a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt);
    end
    cyc();
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_load_use();
    idle();
    cyc();
    set_load_use_rs();
    #1;
    vectors++;
    if (a_ctl !== 5'b11010) begin
      miscompares++;
      $display("[TB] FAIL lu_rs_ctl: got %b want 11010", a_ctl);
    end
    cyc();
    zero_inputs();
    #1;
    vectors++;
    if (a_ctl !== 5'b00000) begin
      miscompares++;
      $display("[TB] FAIL lu_rs_after: got %b want 00000", a_ctl);
    end
    vectors++;
    if (a_stall_cnt !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL lu_rs_cnt: got %0d want 1", a_stall_cnt);
    end
    vectors++;
    if (b_ctl !== 5'b11011) begin
      miscompares++;
      $display("[TB] FAIL lu_b_lstall: got %b want 11011", b_ctl);
    end
    // rt-side match, with a non-matching rs
    cyc();
    zero_inputs();
    idex_memtoreg = 1'b1;
    idex_regwrite = 1'b1;
    idex_rt       = 5'd8;
    ifid_rt       = 5'd8;
    ifid_rs       = 5'd3;
    ifid_uses_rs  = 1'b1;
    ifid_uses_rt  = 1'b1;
    #1;
    vectors++;
    if (a_ctl !== 5'b11010) begin
      miscompares++;
      $display("[TB] FAIL lu_rt_ctl: got %b want 11010", a_ctl);
    end
    // Register fields match but are not read
    cyc();
    ifid_rs      = 5'd8;
    ifid_uses_rs = 1'b0;
    ifid_uses_rt = 1'b0;
    #1;
    vectors++;
    if (a_ctl !== 5'b00000) begin
      miscompares++;
      $display("[TB] FAIL lu_unused_ctl: got %b want 00000", a_ctl);
    end
    // Load that does not write a register
    cyc();
    ifid_uses_rs  = 1'b1;
    idex_regwrite = 1'b0;
    #1;
    vectors++;
    if (a_ctl !== 5'b00000) begin
      miscompares++;
      $display("[TB] FAIL lu_noregwr_ctl: got %b want 00000", a_ctl);
    end
  endtask

  task automatic test_load_zero();
    idle();
    cyc();
    idex_memtoreg = 1'b1;
    idex_regwrite = 1'b1;
    idex_rt       = 5'd0;
    ifid_rs       = 5'd0;
    ifid_rt       = 5'd0;
    ifid_uses_rs  = 1'b1;
    ifid_uses_rt  = 1'b1;
    #1;
    vectors++;
    if ((a_ctl !== 5'b00000) || (b_ctl !== 5'b00000)) begin
      miscompares++;
      $display("[TB] FAIL zero_ctl: got a=%b b=%b want 00000", a_ctl, b_ctl);
    end
    cyc();
    #1;
    vectors++;
    if ((a_stall_cnt !== 16'd0) || (b_stall_cnt !== 4'd0) || (b_ctl !== 5'b00000)) begin
      miscompares++;
      $display("[TB] FAIL zero_cnt: got a=%0d b=%0d bctl=%b want 0 0 00000", a_stall_cnt, b_stall_cnt, b_ctl);
    end
  endtask

  task automatic test_flush_seq();
    logic [4:0] want_b [0:3];
    logic [4:0] want_a [0:3];
    want_b[0] = 5'b00110; want_b[1] = 5'b00111; want_b[2] = 5'b00111; want_b[3] = 5'b00000;
    want_a[0] = 5'b00110; want_a[1] = 5'b00000; want_a[2] = 5'b00000; want_a[3] = 5'b00000;
    idle();
    for (int i = 0; i < 4; i++) begin
      cyc();
      jump_ex = (i == 0);
      #1;
      vectors++;
      if ((b_ctl !== want_b[i]) || (a_ctl !== want_a[i])) begin
        miscompares++;
        $display("[TB] FAIL flush_seq_%0d: got a=%b b=%b want a=%b b=%b", i, a_ctl, b_ctl, want_a[i], want_b[i]);
      end
    end
    vectors++;
    if ((b_flush_cnt !== 4'd3) || (a_flush_cnt !== 16'd1)) begin
      miscompares++;
      $display("[TB] FAIL flush_cnt: got a=%0d b=%0d want a=1 b=3", a_flush_cnt, b_flush_cnt);
    end
  endtask

  task automatic test_redirect_priority();
    idle();
    cyc();
    set_load_use_rs();
    branch_taken_ex = 1'b1;
    #1;
    vectors++;
    if ((a_ctl !== 5'b00110) || (b_ctl !== 5'b00110)) begin
      miscompares++;
      $display("[TB] FAIL prio_ctl: got a=%b b=%b want 00110", a_ctl, b_ctl);
    end
    cyc();
    zero_inputs();
    #1;
    vectors++;
    if ((a_stall_cnt !== 16'd0) || (a_flush_cnt !== 16'd1) || (b_ctl !== 5'b00111)) begin
      miscompares++;
      $display("[TB] FAIL prio_after: got a=%0d/%0d bctl=%b want 0/1 00111", a_stall_cnt, a_flush_cnt, b_ctl);
    end
  endtask

  task automatic test_lstall_redirect();
    logic [4:0] want_b [0:4];
    want_b[0] = 5'b11010; want_b[1] = 5'b00111; want_b[2] = 5'b00111;
    want_b[3] = 5'b00111; want_b[4] = 5'b00000;
    idle();
    for (int i = 0; i < 5; i++) begin
      cyc();
      zero_inputs();
      if (i < 2) set_load_use_rs();
      jregister_ex = (i == 1);
      #1;
      vectors++;
      if (b_ctl !== want_b[i]) begin
        miscompares++;
        $display("[TB] FAIL lstall_redir_%0d: got %b want %b", i, b_ctl, want_b[i]);
      end
    end
    vectors++;
    if ((b_stall_cnt !== 4'd1) || (b_flush_cnt !== 4'd3)) begin
      miscompares++;
      $display("[TB] FAIL lstall_redir_cnt: got %0d/%0d want 1/3", b_stall_cnt, b_flush_cnt);
    end
  endtask

  task automatic test_reset_mid_lstall();
    idle();
    cyc();
    set_load_use_rs();
    #1;
    vectors++;
    if (b_ctl !== 5'b11010) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_start: got %b want 11010", b_ctl);
    end
    cyc();
    reset = 1'b1;
    #1;
    vectors++;
    if ((b_ctl[4:1] !== 4'b0000) || (a_ctl[4:1] !== 4'b0000)) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_forced: got a=%b b=%b want 0000", a_ctl[4:1], b_ctl[4:1]);
    end
    cyc();
    reset = 1'b0;
    zero_inputs();
    #1;
    vectors++;
    if ((b_ctl !== 5'b00000) || (b_stall_cnt !== 4'd0) || (b_flush_cnt !== 4'd0) ||
        (a_stall_cnt !== 16'd0)) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_after: got bctl=%b b=%0d/%0d a=%0d want 00000 0/0 0", b_ctl, b_stall_cnt, b_flush_cnt, a_stall_cnt);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    for (int i = 0; i < 20; i++) begin
      cyc();
      set_load_use_rs();
    end
    cyc();
    clr_cnt = 1'b1;
    #1;
    vectors++;
    if ((b_stall_cnt !== 4'd15) || (a_stall_cnt !== 16'd20)) begin
      miscompares++;
      $display("[TB] FAIL sat_cnt: got a=%0d b=%0d want a=20 b=15", a_stall_cnt, b_stall_cnt);
    end
    vectors++;
    if ((a_ctl !== 5'b11010) || (b_pc_stall !== 1'b1)) begin
      miscompares++;
      $display("[TB] FAIL sat_clr_stalling: got a=%b bpc=%b want 11010 1", a_ctl, b_pc_stall);
    end
    cyc();
    clr_cnt = 1'b0;
    zero_inputs();
    #1;
    vectors++;
    if ((b_stall_cnt !== 4'd0) || (a_stall_cnt !== 16'd0)) begin
      miscompares++;
      $display("[TB] FAIL sat_clr: got a=%0d b=%0d want 0", a_stall_cnt, b_stall_cnt);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_load_use();
    test_load_zero();
    test_flush_seq();
    test_redirect_priority();
    test_lstall_redirect();
    test_reset_mid_lstall();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
